// File: rtl/reg_pipe_elastic_pkg.sv
// reg_pipe_elastic_pkg: shared defaults, count-width helper and transfer encoding
package reg_pipe_elastic_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  typedef enum logic [1:0] {XFER_NONE, XFER_IN, XFER_OUT, XFER_BOTH} xfer_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/reg_pipe_elastic_if.sv
// reg_pipe_elastic_if: valid/ready data stream
interface reg_pipe_elastic_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/reg_pipe_elastic_stage.sv
// reg_pipe_elastic_stage: one pipeline slot; flush beats load beats clear, empty slots keep their data
module reg_pipe_elastic_stage #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_v,
  output logic [WIDTH-1:0] o_d
);
  logic             r_v;
  logic [WIDTH-1:0] r_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_v <= 1'b0;
      r_d <= INIT;
    end else if (i_flush) begin
      r_v <= 1'b0;
      r_d <= INIT;
    end else if (i_load) begin
      r_v <= 1'b1;
      r_d <= i_d;
    end else if (i_clear) begin
      r_v <= 1'b0;
    end
  assign o_v = r_v;
  assign o_d = r_d;
endmodule

// File: rtl/reg_pipe_elastic.sv
// reg_pipe_elastic: DEPTH-stage elastic register pipeline with bubble collapsing, CE, flush and occupancy count
module reg_pipe_elastic
  import reg_pipe_elastic_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter int               DEPTH = DEF_DEPTH,
  parameter logic [WIDTH-1:0] INIT  = '0,
  localparam int              CW    = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ce,
  input  logic                  i_clr,
  reg_pipe_elastic_if.slave     i_s,
  reg_pipe_elastic_if.master    o_m,
  output logic [CW-1:0]         o_count
);
  logic             w_en;
  logic             w_in;
  logic             w_out;
  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_load;
  logic [WIDTH-1:0] w_d   [DEPTH];
  logic [WIDTH-1:0] w_src [DEPTH];
  logic [CW-1:0]    r_count;
  xfer_e            w_xfer;
  assign w_en = i_ce & ~i_clr;
  // advance resolves from the output end so a draining stage frees its predecessor in the same cycle
  always_comb begin
    w_adv = '0;
    w_adv[DEPTH-1] = w_v[DEPTH-1] & o_m.ready & w_en;
    for (int k = DEPTH - 2; k >= 0; k--) w_adv[k] = w_v[k] & (~w_v[k+1] | w_adv[k+1]) & w_en;
  end
  assign i_s.ready = w_en & (~w_v[0] | w_adv[0]);
  assign w_in      = i_s.valid & i_s.ready;
  assign w_out     = w_adv[DEPTH-1];
  assign o_m.data  = w_d[DEPTH-1];
  assign o_m.valid = w_v[DEPTH-1] & w_en;
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_load[g] = w_in;
      assign w_src[g]  = i_s.data;
    end else begin : g_body
      assign w_load[g] = w_adv[g-1];
      assign w_src[g]  = w_d[g-1];
    end
    reg_pipe_elastic_stage #(.WIDTH(WIDTH), .INIT(INIT)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[g]),
      .i_clear (w_adv[g]),
      .i_flush (i_clr),
      .i_d     (w_src[g]),
      .o_v     (w_v[g]),
      .o_d     (w_d[g])
    );
  end
  assign w_xfer = xfer_e'({w_out, w_in});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (i_clr) r_count <= '0;
    else r_count <= w_xfer == XFER_IN ? r_count + CW'(1) : w_xfer == XFER_OUT ? r_count - CW'(1) : r_count;
  assign o_count = r_count;
endmodule

// File: tb/tb_reg_pipe_elastic.sv
// tb_reg_pipe_elastic: scoreboarded bench for DEPTH=4 (INIT=A5) and DEPTH=1 (INIT=3C) pipelines
module tb_reg_pipe_elastic;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce4 = 1'b1, clr4 = 1'b0, ce1 = 1'b1, clr1 = 1'b0;
  logic [2:0] cnt4;
  logic [0:0] cnt1;
  int checks = 0, errors = 0, mc4 = 0, mc1 = 0;
  logic [7:0] q4 [$];
  logic [7:0] q1 [$];
  logic [7:0] e4, e1;
  always #5 clk = ~clk;
  reg_pipe_elastic_if #(.WIDTH(8)) s4 (), m4 (), s1 (), m1 ();
  reg_pipe_elastic #(.WIDTH(8), .DEPTH(4), .INIT(8'hA5)) u4 (
    .clk(clk), .rst_n(rst_n), .i_ce(ce4), .i_clr(clr4), .i_s(s4), .o_m(m4), .o_count(cnt4));
  reg_pipe_elastic #(.WIDTH(8), .DEPTH(1), .INIT(8'h3C)) u1 (
    .clk(clk), .rst_n(rst_n), .i_ce(ce1), .i_clr(clr1), .i_s(s1), .o_m(m1), .o_count(cnt1));
  always @(negedge clk) if (rst_n) begin
    checks++; if (cnt4 !== 3'(mc4)) begin errors++; $display("FAIL count4 got %0d exp %0d", cnt4, mc4); end
    if (clr4) begin q4.delete(); mc4 = 0; end
    else begin
      if (m4.valid && m4.ready) begin
        checks++;
        if (q4.size() == 0) begin errors++; $display("FAIL sb4 got %h exp none", m4.data); end
        else begin e4 = q4.pop_front(); if (m4.data !== e4) begin errors++; $display("FAIL sb4 got %h exp %h", m4.data, e4); end end
        mc4--;
      end
      if (s4.valid && s4.ready) begin q4.push_back(s4.data); mc4++; end
    end
  end
  always @(negedge clk) if (rst_n) begin
    checks++; if (cnt1 !== 1'(mc1)) begin errors++; $display("FAIL count1 got %0d exp %0d", cnt1, mc1); end
    if (clr1) begin q1.delete(); mc1 = 0; end
    else begin
      if (m1.valid && m1.ready) begin
        checks++;
        if (q1.size() == 0) begin errors++; $display("FAIL sb1 got %h exp none", m1.data); end
        else begin e1 = q1.pop_front(); if (m1.data !== e1) begin errors++; $display("FAIL sb1 got %h exp %h", m1.data, e1); end end
        mc1--;
      end
      if (s1.valid && s1.ready) begin q1.push_back(s1.data); mc1++; end
    end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    m4.ready = 1'b0;
    s4.valid = 1'b1; s4.data = 8'h5A; step();
    s4.data = 8'h5B; step();
    s4.valid = 1'b0; step();
    checks++; if (cnt4 !== 3'd2) begin errors++; $display("FAIL pre_reset_count got %0d exp 2", cnt4); end
    #3 rst_n = 1'b0; #1;
    checks++; if (m4.data !== 8'hA5) begin errors++; $display("FAIL reset_o got %h exp a5", m4.data); end
    checks++; if (m4.valid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got %b exp 0", m4.valid); end
    checks++; if (cnt4 !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt4); end
    checks++; if (s4.ready !== 1'b1) begin errors++; $display("FAIL reset_iready got %b exp 1", s4.ready); end
    checks++; if (m1.data !== 8'h3C) begin errors++; $display("FAIL reset_o1 got %h exp 3c", m1.data); end
    q4.delete(); q1.delete(); mc4 = 0; mc1 = 0;
    step(); rst_n = 1'b1; step();
    checks++; if (cnt4 !== 3'd0 || m4.valid !== 1'b0) begin errors++; $display("FAIL post_reset got cnt %0d valid %b exp 0 0", cnt4, m4.valid); end
  endtask
  task automatic test_stream();
    m4.ready = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      s4.valid = 1'b1; s4.data = 8'(j); step();
      checks++; if (m4.valid !== (j >= 4)) begin errors++; $display("FAIL stream_valid%0d got %b exp %b", j, m4.valid, j >= 4); end
      checks++; if (cnt4 !== 3'(j < 4 ? j : 4)) begin errors++; $display("FAIL stream_count%0d got %0d exp %0d", j, cnt4, j < 4 ? j : 4); end
    end
    s4.valid = 1'b0; repeat (4) step();
    checks++; if (cnt4 !== 3'd0 || q4.size() != 0) begin errors++; $display("FAIL stream_drain got cnt %0d q %0d exp 0 0", cnt4, q4.size()); end
  endtask
  task automatic test_backpressure();
    m4.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s4.valid = 1'b1; s4.data = 8'(8'h11 * (i + 1)); #1;
      checks++; if (s4.ready !== 1'b1) begin errors++; $display("FAIL bp_accept%0d got %b exp 1", i, s4.ready); end
      step();
    end
    s4.data = 8'h55; #1;
    checks++; if (s4.ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", s4.ready); end
    checks++; if (cnt4 !== 3'd4) begin errors++; $display("FAIL bp_full_count got %0d exp 4", cnt4); end
    checks++; if (m4.data !== 8'h11 || m4.valid !== 1'b1) begin errors++; $display("FAIL bp_head got %h/%b exp 11/1", m4.data, m4.valid); end
    repeat (2) step();
    checks++; if (s4.ready !== 1'b0 || cnt4 !== 3'd4) begin errors++; $display("FAIL bp_hold got %b/%0d exp 0/4", s4.ready, cnt4); end
    m4.ready = 1'b1; #1;
    checks++; if (s4.ready !== 1'b1) begin errors++; $display("FAIL bp_ready_path got %b exp 1", s4.ready); end
    step(); s4.valid = 1'b0;
    checks++; if (cnt4 !== 3'd4) begin errors++; $display("FAIL bp_full_xfer got %0d exp 4", cnt4); end
    for (int t = 0; t < 10 && cnt4 != 3'd0; t++) step();
    checks++; if (cnt4 !== 3'd0 || q4.size() != 0) begin errors++; $display("FAIL bp_drain got cnt %0d q %0d exp 0 0", cnt4, q4.size()); end
  endtask
  task automatic test_bubble();
    m4.ready = 1'b0;
    s4.valid = 1'b1; s4.data = 8'h01; step();
    s4.valid = 1'b0; repeat (2) step();
    s4.valid = 1'b1; s4.data = 8'h02; step();
    s4.valid = 1'b0; repeat (2) step();
    checks++; if (cnt4 !== 3'd2) begin errors++; $display("FAIL bubble_count got %0d exp 2", cnt4); end
    checks++; if (m4.data !== 8'h01 || m4.valid !== 1'b1) begin errors++; $display("FAIL bubble_head got %h/%b exp 01/1", m4.data, m4.valid); end
    m4.ready = 1'b1; step();
    checks++; if (m4.data !== 8'h02 || m4.valid !== 1'b1 || cnt4 !== 3'd1) begin errors++; $display("FAIL bubble_next got %h/%b/%0d exp 02/1/1", m4.data, m4.valid, cnt4); end
    step();
    checks++; if (cnt4 !== 3'd0) begin errors++; $display("FAIL bubble_drain got %0d exp 0", cnt4); end
  endtask
  task automatic test_flush();
    m4.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin s4.valid = 1'b1; s4.data = 8'(8'hC1 + i); step(); end
    s4.valid = 1'b0; step();
    checks++; if (cnt4 !== 3'd3 || m4.data !== 8'hC1) begin errors++; $display("FAIL flush_pre got %0d/%h exp 3/c1", cnt4, m4.data); end
    ce4 = 1'b0; s4.valid = 1'b1; s4.data = 8'h77; #1;
    checks++; if (s4.ready !== 1'b0 || m4.valid !== 1'b0) begin errors++; $display("FAIL ce_mask got %b/%b exp 0/0", s4.ready, m4.valid); end
    repeat (2) step();
    checks++; if (cnt4 !== 3'd3 || m4.data !== 8'hC1) begin errors++; $display("FAIL ce_hold got %0d/%h exp 3/c1", cnt4, m4.data); end
    clr4 = 1'b1; #1;
    checks++; if (s4.ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %b exp 0", s4.ready); end
    step(); clr4 = 1'b0; ce4 = 1'b1; s4.valid = 1'b0; #1;
    checks++; if (cnt4 !== 3'd0 || m4.data !== 8'hA5 || m4.valid !== 1'b0) begin errors++; $display("FAIL flush_post got %0d/%h/%b exp 0/a5/0", cnt4, m4.data, m4.valid); end
    step();
  endtask
  task automatic test_depth1();
    m1.ready = 1'b0; s1.valid = 1'b1; s1.data = 8'h10; #1;
    checks++; if (s1.ready !== 1'b1) begin errors++; $display("FAIL d1_empty_ready got %b exp 1", s1.ready); end
    step();
    checks++; if (cnt1 !== 1'b1 || s1.ready !== 1'b0 || m1.data !== 8'h10) begin errors++; $display("FAIL d1_full got %0d/%b/%h exp 1/0/10", cnt1, s1.ready, m1.data); end
    m1.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s1.data = 8'(8'h10 + i); #1;
      checks++; if (s1.ready !== 1'b1) begin errors++; $display("FAIL d1_ready%0d got %b exp 1", i, s1.ready); end
      step();
      checks++; if (cnt1 !== 1'b1 || m1.valid !== 1'b1 || m1.data !== 8'(8'h10 + i)) begin errors++; $display("FAIL d1_xfer%0d got %0d/%b/%h exp 1/1/%h", i, cnt1, m1.valid, m1.data, 8'(8'h10 + i)); end
    end
    s1.valid = 1'b0; step();
    checks++; if (cnt1 !== 1'b0 || q1.size() != 0) begin errors++; $display("FAIL d1_drain got %0d q %0d exp 0 0", cnt1, q1.size()); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    s4.valid = 1'b0; s4.data = '0; m4.ready = 1'b0;
    s1.valid = 1'b0; s1.data = '0; m1.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_depth1();
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_pipe_elastic.md
# reg_pipe_elastic

Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit registers with valid/ready flow control, per-stage bubble collapsing, global clock enable, synchronous flush and asynchronous active-low reset to a programmable INIT value. It generalises the fixed 8-bit single register into a back-pressurable delay line. It sits between streaming producers and consumers that need register retiming with stall support.

## Interface
- WIDTH, 8: data width in bits (≥1)
- DEPTH, 4: number of register stages (≥1)
- INIT, 0: WIDTH-bit value loaded into every data register on reset and flush
- CLK  in  1  clock, all state updates on rising edge
- ASYNCRESETN  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- CE  in  1  clock enable; low freezes all state and masks both handshakes
- CLR  in  1  synchronous flush, higher priority than CE
- I  in  WIDTH  input data
- I_VALID  in  1  input data valid
- I_READY  out  1  pipeline can accept I this cycle
- O  out  WIDTH  data of last stage (stage DEPTH-1)
- O_VALID  out  1  last stage holds valid data
- O_READY  in  1  consumer accepts O this cycle
- COUNT  out  clog2(DEPTH+1)  number of valid stages, 0..DEPTH

## Operation
- State per stage k: valid bit v[k], data d[k]. Stage 0 is input side.
- Input transfer: I_VALID & I_READY at an edge; output transfer: O_VALID & O_READY.
- adv[DEPTH-1] = v[DEPTH-1] & O_READY & CE & ~CLR.
- Stage k < DEPTH-1 moves forward when v[k] & (~v[k+1] | adv[k+1]) & CE & ~CLR (bubble collapsing).
- I_READY = CE & ~CLR & (~v[0] | adv[0]).
- On move/load, d of the destination takes source data and v goes 1; a stage whose contents leave with no replacement clears v; d holds its last value (no data toggling on empty stages).
- O = d[DEPTH-1] always; O_VALID = v[DEPTH-1] & CE & ~CLR.
- COUNT = popcount(v), registered as a counter: +1 on input transfer, −1 on output transfer, unchanged when both or neither.
- CLR at an edge: all v ← 0, all d ← INIT, COUNT ← 0; I_READY and O_VALID are 0 in that cycle, so no transfer occurs.
- CE low (CLR low): no state change, I_READY = 0, O_VALID = 0.
- Data order preserved; no duplication or loss except by CLR/reset.

## Timing
- Reset (ASYNCRESETN low, immediate): v = 0, d = INIT, COUNT = 0, O = INIT, O_VALID = 0, I_READY = 0 only while CE low or CLR high, else 1.
- Latency: item accepted at edge t is at O with O_VALID = 1 after edge t+DEPTH−1, i.e. DEPTH cycles from presentation into an empty, unstalled pipe.
- Throughput: one item per cycle when O_READY held high.
- Ready path is combinational O_READY → I_READY through DEPTH stages; no combinational path I_VALID → O_VALID.
- Full (COUNT = DEPTH) with O_READY = 1: simultaneous input and output transfer, COUNT stays DEPTH.
- Full with O_READY = 0: I_READY = 0.
- Reset deasserted mid-stream: first edge after release behaves as empty pipe.
- DEPTH = 1: single register with I_READY = ~v[0] | O_READY.

## Structure
- Package reg_pipe_pkg: count-width function clog2(DEPTH+1), COUNT type helper.
- Sub-module reg_pipe_stage (WIDTH, INIT): one slot holding v/d with load, clear, flush inputs and async reset; instantiated DEPTH times by generate; top holds advance logic and counter.

## Test plan
- Reset: WIDTH=8, DEPTH=4, INIT=0xA5, ASYNCRESETN low mid-cycle -> O=0xA5, O_VALID=0, COUNT=0 immediately.
- Streaming: O_READY=1, inputs 0x01..0x10 back-to-back -> O_VALID first after 4 cycles, outputs 0x01..0x10 in order, one per cycle, COUNT steady 4.
- Back-pressure: O_READY=0, push 0x11,0x22,0x33,0x44,0x55 -> first four accepted, I_READY=0 on 5th, COUNT=4; release O_READY -> 0x11..0x44 then 0x55.
- Bubble collapse: push 0x01, idle 2 cycles, push 0x02 with O_READY=0 -> both pack into stages 3,2; COUNT=2.
- Flush/CE: COUNT=3, assert CLR with CE low and I_VALID=1 -> next cycle COUNT=0, O=INIT, input not accepted; CE low alone holds COUNT and O.
- DEPTH=1 variant: full, I_VALID=1, O_READY=1 -> simultaneous transfer every cycle, COUNT stays 1.
